// File: rtl/shift_enc_pkg.sv
// rtl/shift_enc_pkg.sv - shared constants, FSM state and byte index map for the shift encoder/decoder
package shift_enc_pkg;

  localparam int NBYTES_DEF = 8;
  localparam int PRIME_DEF  = 7;
  localparam int IDXW       = $clog2(NBYTES_DEF);

  typedef enum logic [1:0] {IDLE, KEYSUM, SCATTER, DONE} state_t;

  // Byte slot paired with step i; nbytes is a power of two, so the mask is the modulo.
  function automatic int idx(input int s, input int i,
                             input int nbytes = NBYTES_DEF, input int prime = PRIME_DEF);
    return (s + i * prime) & (nbytes - 1);
  endfunction

endpackage

// File: rtl/shift_key_sum.sv
// rtl/shift_key_sum.sv - key byte sum mod NBYTES; serial accumulator, or adder tree with SHIFT_DEC_FAST_KEY_EN
module shift_key_sum
  import shift_enc_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int IW     = IDXW
) (
`ifndef SHIFT_DEC_FAST_KEY_EN
  input  logic                clk,
  input  logic                set,
  input  logic                clr,
  input  logic                en,
  input  logic [IW-1:0]       cnt,
`endif
  input  logic [0:8*NBYTES-1] key,
  output logic [IW-1:0]       sum
);

`ifdef SHIFT_DEC_FAST_KEY_EN
  // Only the low IW bits of each byte survive the modulo, so truncate before adding.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NBYTES; i++) begin
      sum = sum + IW'(key[i*8 +: 8]);
    end
  end
`else
  logic [IW-1:0] acc;

  // sum is the value acc takes after folding in byte cnt.
  always_comb sum = acc + IW'(key[int'(cnt)*8 +: 8]);

  always_ff @(posedge clk) begin
    if (set || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end
`endif

endmodule

// File: rtl/inverse_shift_decoding.sv
// rtl/inverse_shift_decoding.sv - keyed shift-permutation decoder, one byte per cycle; SHIFT_DEC_FAST_KEY_EN skips KEYSUM
module inverse_shift_decoding
  import shift_enc_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int PRIME  = PRIME_DEF
) (
  input  logic                clk,
  input  logic                set,
  input  logic                start,
  input  logic [0:8*NBYTES-1] data_in,
  input  logic [0:8*NBYTES-1] key,
  input  logic                out_ack,
  output logic                in_ready,
  output logic                status,
  output logic [0:8*NBYTES-1] data_out
);

  localparam int            IW   = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t              state;
  logic [0:8*NBYTES-1] din_q;
  logic [IW-1:0]       cnt;
  logic [IW-1:0]       s_q;
  logic [IW-1:0]       key_sum;
  logic [IW-1:0]       scat_idx;
  logic                accept;

  assign in_ready = (state == IDLE);
  assign accept   = start & in_ready;
  assign scat_idx = IW'(idx(int'(s_q), int'(cnt), NBYTES, PRIME));

`ifdef SHIFT_DEC_FAST_KEY_EN
  // The live key is summed on the accept edge, so no key register is needed.
  shift_key_sum #(.NBYTES(NBYTES), .IW(IW)) u_key_sum (
    .key (key),
    .sum (key_sum)
  );
`else
  logic [0:8*NBYTES-1] key_q;

  shift_key_sum #(.NBYTES(NBYTES), .IW(IW)) u_key_sum (
    .clk (clk),
    .set (set),
    .clr (accept),
    .en  (state == KEYSUM),
    .cnt (cnt),
    .key (key_q),
    .sum (key_sum)
  );
`endif

  always_ff @(posedge clk) begin
    if (set) begin
      state    <= IDLE;
      din_q    <= '0;
      cnt      <= '0;
      s_q      <= '0;
      status   <= 1'b0;
      data_out <= '0;
`ifndef SHIFT_DEC_FAST_KEY_EN
      key_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            din_q <= data_in;
            cnt   <= '0;
`ifdef SHIFT_DEC_FAST_KEY_EN
            s_q   <= key_sum;
            state <= SCATTER;
`else
            key_q <= key;
            state <= KEYSUM;
`endif
          end
        end
        KEYSUM: begin
          cnt <= cnt + IW'(1);
          if (cnt == LAST) begin
            s_q   <= key_sum;
            state <= SCATTER;
          end
        end
        SCATTER: begin
          data_out[int'(scat_idx)*8 +: 8] <= din_q[int'(cnt)*8 +: 8];
          cnt <= cnt + IW'(1);
          if (cnt == LAST) begin
            status <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ack) begin
            status <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_shift_decoding.sv
// tb/tb_inverse_shift_decoding.sv - scoreboard bench: round trips through an encoder model, handshake and abort
`timescale 1ns/1ps
module tb_inverse_shift_decoding;

  localparam int N = 8;
  localparam int P = 7;
`ifdef SHIFT_DEC_FAST_KEY_EN
  localparam int LAT = N;
`else
  localparam int LAT = 2 * N;
`endif

  logic           clk = 1'b0;
  logic           set;
  logic           start;
  logic           out_ack;
  logic           in_ready;
  logic           status;
  logic [0:8*N-1] data_in;
  logic [0:8*N-1] key;
  logic [0:8*N-1] data_out;

  always #5 clk = ~clk;

  inverse_shift_decoding dut (
    .clk      (clk),
    .set      (set),
    .start    (start),
    .data_in  (data_in),
    .key      (key),
    .out_ack  (out_ack),
    .in_ready (in_ready),
    .status   (status),
    .data_out (data_out)
  );

  typedef struct {
    logic [0:8*N-1] data;
    int             rise;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic prev_status = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Encoder: output byte i comes from input byte (s + i*P) mod N, s = key byte sum mod N.
  function automatic logic [0:8*N-1] encode(input logic [0:8*N-1] x, input logic [0:8*N-1] k);
    int s;
    logic [0:8*N-1] y;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(k[i*8 +: 8]);
    s = s % N;
    for (int i = 0; i < N; i++) y[i*8 +: 8] = x[((s + i * P) % N) * 8 +: 8];
    return y;
  endfunction

  function automatic logic [0:8*N-1] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every status rise must match the oldest outstanding word and its latency.
  always @(negedge clk) begin
    exp_t e;
    if (status && !prev_status) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got data_out=%h with no request outstanding", data_out);
      end else begin
        e = sb.pop_front();
        check("data_out", data_out, e.data);
        check("latency", 64'(cyc), 64'(e.rise));
      end
    end
    prev_status = status;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL ready_timeout: in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic issue(input logic [0:8*N-1] din, input logic [0:8*N-1] k, input logic [0:8*N-1] exp_out);
    wait_ready();
    data_in = din;
    key     = k;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = rnd64();
    key     = rnd64();
    sb.push_back('{data: exp_out, rise: cyc + LAT});
  endtask

  // While busy, optionally throw start/out_ack noise at the DUT; both must be ignored.
  task automatic wait_status(input bit noise);
    int n;
    n = 0;
    while (!status && n < 4 * N) begin
      if (noise) begin
        check("busy_in_ready", 64'(in_ready), 64'd0);
        start   = 1'($urandom_range(0, 1));
        out_ack = 1'($urandom_range(0, 1));
        data_in = rnd64();
        key     = rnd64();
      end
      tick();
      n++;
    end
    start   = 1'b0;
    out_ack = 1'b0;
    if (!status) begin
      checks++;
      $display("FAIL status_timeout: status=%0b want 1", status);
    end
  endtask

  task automatic finish_word(input logic [0:8*N-1] exp_out, input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      check("hold_status", 64'(status), 64'd1);
      check("hold_data", data_out, exp_out);
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        data_in = rnd64();
      end
      tick();
    end
    start   = 1'b0;
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("ack_status", 64'(status), 64'd0);
    check("ack_data", data_out, exp_out);
    check("ack_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic round_trip(input logic [0:8*N-1] p, input logic [0:8*N-1] k, input int hold, input bit noise);
    issue(encode(p, k), k, p);
    wait_status(noise);
    finish_word(p, hold, noise);
  endtask

  initial begin
    logic [0:8*N-1] p1, p2, k1, k2;
    set = 1'b1; start = 1'b0; out_ack = 1'b0; data_in = '0; key = '0;
    tick();
    tick();
    set = 1'b0;
    check("rst_status", 64'(status), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("idle_ack_ready", 64'(in_ready), 64'd1);

    issue(64'h0001020304050607, 64'h0, 64'h0007060504030201);
    wait_status(1'b0);
    finish_word(64'h0007060504030201, 20, 1'b1);

    issue(64'h0001020304050607, 64'h0100000000000000, 64'h0100070605040302);
    wait_status(1'b1);
    finish_word(64'h0100070605040302, 2, 1'b0);

    round_trip(64'h0001020304050607, 64'h1122334455667788, 1, 1'b0);

    // Abort in the third SCATTER cycle, then a clean decode.
    p1 = rnd64(); k1 = rnd64();
    wait_ready();
    data_in = encode(p1, k1); key = k1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - N + 2) tick();
    check("pre_abort_status", 64'(status), 64'd0);
    set = 1'b1;
    tick();
    set = 1'b0;
    check("abort_status", 64'(status), 64'd0);
    check("abort_data", data_out, 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    round_trip(rnd64(), rnd64(), 2, 1'b0);

    // start held through the acknowledge is taken on the first IDLE cycle.
    p1 = rnd64(); k1 = rnd64(); p2 = rnd64(); k2 = rnd64();
    issue(encode(p1, k1), k1, p1);
    wait_status(1'b0);
    data_in = encode(p2, k2); key = k2; start = 1'b1; out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("handoff_status", 64'(status), 64'd0);
    check("handoff_ready", 64'(in_ready), 64'd1);
    tick();
    start = 1'b0; data_in = rnd64(); key = rnd64();
    sb.push_back('{data: p2, rise: cyc + LAT});
    wait_status(1'b0);
    finish_word(p2, 1, 1'b0);

    for (int t = 0; t < 200; t++) begin
      round_trip(rnd64(), rnd64(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (4) tick();
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inverse_shift_decoding.md
# inverse_shift_decoding

Sequential decoder for the 8-byte keyed shift-permutation encoding used on the EVM data path. The encoder emits byte i of its output from input byte (s + i·PRIME) mod NBYTES, where s = (sum of key bytes) mod NBYTES. This block takes an encoded word plus the same key and scatters each byte back to its original slot, one byte per cycle. It recovers the plaintext word and holds it behind a status/acknowledge handshake. It sits on the receive side, downstream of storage/transport, and consumes the encoder's output word unchanged.

## Interface
- NBYTES, 8, bytes per word; power of two, ≥2.
- PRIME, 7, stride; odd, so it is coprime with NBYTES.
- clk  in  1  clock; all state updates on posedge.
- set  in  1  synchronous, active-high reset/clear; one clock, reset is synchronous and active-high.
- start  in  1  request; accepted on a posedge where start & in_ready.
- data_in  in  [0:8·NBYTES-1]  encoded word; byte i = data_in[i*8 +: 8], byte 0 is the MSB end.
- key  in  [0:8·NBYTES-1]  key bytes, same ordering.
- out_ack  in  1  consumer acknowledge; releases the DONE state.
- in_ready  out  1  high only in IDLE; combinational from state.
- status  out  1  registered; high while a decoded word is held.
- data_out  out  [0:8·NBYTES-1]  registered decoded word.

## Operation
- FSM states: IDLE, KEYSUM, SCATTER, DONE.
- IDLE:
  - On accept, latch data_in → din_q, clear key accumulator acc, cnt←0, go to KEYSUM.
  - Key bytes are read from key_q; key is latched with data_in.
- KEYSUM:
  - Each cycle, acc ← (acc + key_q byte cnt) mod NBYTES. Only the low log2(NBYTES) bits matter; carries are discarded.
  - After byte NBYTES-1, s ← acc, cnt←0, go to SCATTER.
- SCATTER:
  - Each cycle, idx = (s + cnt·PRIME) mod NBYTES, computed in log2(NBYTES) bits with wrap; data_out[idx] ← din_q byte cnt.
  - Every index is written exactly once.
  - On cnt = NBYTES-1, status ← 1, go to DONE.
- DONE:
  - Hold data_out and status.
  - out_ack → status ← 0, go to IDLE; data_out keeps its value.
  - start is ignored, because in_ready = 0.
- Intermediate data_out bytes are visible during SCATTER. Consumers sample data_out only while status = 1.
- For the default parameters the map is an involution: decode(x) = encode(x) for the same key. The bench exploits this, but the RTL must still implement the scatter form above.

## Timing
- Reset (set = 1):
  - status = 0, data_out = 0, state = IDLE, so in_ready = 1 on the next cycle.
  - Counters, acc and s are cleared.
- set has priority over every other input in every state. Asserting it mid-KEYSUM or mid-SCATTER aborts the operation; the partial word is lost and data_out is cleared.
- Latency: status rises at the posedge that is 2·NBYTES edges after the accept edge (16 with defaults).
- Throughput: at most one word per 2·NBYTES+2 cycles. Time spent in DONE adds directly to this.
- out_ack outside DONE has no effect.
- start held high across DONE→IDLE is accepted on the first IDLE cycle.

## Configuration
- SHIFT_DEC_FAST_KEY_EN
  - Defined: KEYSUM is removed. The accept edge computes s from the full key in a single adder tree and enters SCATTER directly. Latency = NBYTES edges (8 with defaults).
  - Undefined: the serial KEYSUM path described above, latency 2·NBYTES.
  - data_out is identical in both modes.

## Structure
- Shared package shift_enc_pkg holds the following, so the encoder and decoder share one definition:
  - NBYTES_DEF = 8, PRIME_DEF = 7, and IDXW = $clog2(NBYTES).
  - The FSM state typedef.
  - An index function idx(s, i).
- Sub-module shift_key_sum is the key-sum accumulator: serial mode, plus the adder-tree variant selected by SHIFT_DEC_FAST_KEY_EN.

## Test plan
- Zero key: key = 0, data_in = 00 01 02 03 04 05 06 07 → data_out = 00 07 06 05 04 03 02 01; status rises 16 edges after accept.
- Shift by one: key = 01 00 00 00 00 00 00 00, same data → data_out = 01 00 07 06 05 04 03 02.
- Round trip: key = 11 22 33 44 55 66 77 88 (s = 4), plus 200 random data/key pairs → encoder output fed through this block equals the original data_in.
- Abort: set pulsed in the 3rd SCATTER cycle → next cycle status = 0, data_out = 0, in_ready = 1; a new request then decodes correctly.
- Handshake:
  - start pulsed while busy or in DONE → ignored.
  - status and data_out held for 20 cycles without out_ack.
  - out_ack → status = 0 on the next edge; data_out unchanged.
- With SHIFT_DEC_FAST_KEY_EN defined, zero-key case → same data_out; status rises 8 edges after accept.
